multi_sonar_scanner: RTL and testbench

Parametrised N-channel ultrasonic ranging engine, successor to the fixed 3-sonar front end.
- Fires HC-SR04-style triggers one channel at a time, round-robin, with a settling gap between channels to avoid acoustic crosstalk.
- Measures each echo pulse width, converts it to whole centimetres with round-to-nearest, and streams one result per enabled channel over a valid/ready interface to the serial transmitter.
- Supports continuous and single-shot scan modes, a per-channel enable mask, and echo timeout detection.

---
 rtl/sonar_pkg.sv | 41 ++++
 rtl/echo_width_meter.sv | 77 +++++++
 rtl/multi_sonar_scanner.sv | 225 ++++++++++++++++++++++
 tb/tb_multi_sonar_scanner.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sonar_pkg.sv
// Shared definitions for the multi-channel sonar scanner.
// Holds the scanner state encoding, the microsecond-to-cycle helper and
// the cycle counts derived from the default 50 MHz configuration.
package sonar_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_EMIT,
        ST_GAP,
        ST_DONE
    } scan_state_t;

    // 64-bit intermediate so that large us * clk_hz products do not overflow
    function automatic int unsigned us_to_cycles(input longint unsigned us,
                                                 input longint unsigned clk_hz);
        longint unsigned cyc;
        cyc = (us * clk_hz) / 64'd1_000_000;
        return cyc[31:0];
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // Cycle counts for the default configuration (50 MHz, 2941 cycles/cm)
    localparam int unsigned TRIG_CYC   = us_to_cycles(64'd10, 64'd50_000_000);
    localparam int unsigned NOECHO_CYC = us_to_cycles(64'd30_000, 64'd50_000_000);
    localparam int unsigned GAP_CYC    = us_to_cycles(64'd1_000, 64'd50_000_000);
    localparam int unsigned HALF_CM    = (2941 + 1) / 2;

endpackage

// File: rtl/echo_width_meter.sv
// Echo pulse width meter.
// Counts clock cycles while the (already synchronised) echo is high and
// converts them to whole centimetres, rounding to nearest on the falling
// edge. Stops at MAX_CM and flags saturation.
// Ports:
//   clock, reset     clock and asynchronous active-low reset
//   clear            zero the measurement (priority over enable)
//   enable           measurement window; counts while echo_in is high
//   echo_in          synchronised echo of the selected channel
//   cm               measured distance in centimetres
//   done             measurement finished (echo fell or saturated)
//   saturated        distance reached MAX_CM
module echo_width_meter
    import sonar_pkg::*;
#(
    parameter int unsigned CYC_PER_CM = 2941,
    parameter int unsigned MAX_CM     = 400,
    parameter int unsigned W_DIST     = 9
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              echo_in,
    output logic [W_DIST-1:0] cm,
    output logic              done,
    output logic              saturated
);

    localparam int unsigned HALF  = (CYC_PER_CM + 1) / 2;
    localparam int          SUB_W = (CYC_PER_CM > 1) ? $clog2(CYC_PER_CM) : 1;

    localparam logic [SUB_W-1:0]  SUB_LAST = SUB_W'(CYC_PER_CM - 1);
    localparam logic [SUB_W-1:0]  SUB_HALF = SUB_W'(HALF);
    localparam logic [W_DIST-1:0] CM_LAST  = W_DIST'(MAX_CM - 1);
    localparam logic [W_DIST-1:0] CM_MAX   = W_DIST'(MAX_CM);

    logic [SUB_W-1:0] sub;

    // Once done is set the result is frozen until the next clear
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sub       <= '0;
            cm        <= '0;
            done      <= 1'b0;
            saturated <= 1'b0;
        end else if (clear) begin
            sub       <= '0;
            cm        <= '0;
            done      <= 1'b0;
            saturated <= 1'b0;
        end else if (enable && !done) begin
            if (echo_in) begin
                if (sub == SUB_LAST) begin
                    sub <= '0;
                    if (cm == CM_LAST) begin
                        cm        <= CM_MAX;
                        saturated <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        cm <= cm + 1'b1;
                    end
                end else begin
                    sub <= sub + 1'b1;
                end
            end else begin
                // Falling edge: round the partial centimetre to nearest
                done <= 1'b1;
                if (sub >= SUB_HALF) begin
                    cm <= cm + 1'b1;
                    if (cm == CM_LAST) saturated <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/multi_sonar_scanner.sv
// N-channel round-robin ultrasonic ranging engine.
// Fires one trigger at a time, measures the echo width of that channel,
// and streams one distance result per enabled channel over valid/ready.
// Ports:
//   clock, reset       clock and asynchronous active-low reset
//   ligar              scanning enable (level)
//   modo               0 = continuous, 1 = single scan per start pulse
//   start              single-shot request
//   ch_mask            channel enables, latched at scan start
//   echo               raw asynchronous echo inputs
//   trigger            trigger pulses, one-hot or zero
//   dist_data          distance in cm
//   dist_ch            channel index of the result
//   dist_timeout       result invalid (no echo or saturated)
//   dist_valid         result available
//   dist_ready         consumer accepts the result
//   busy               scan in progress
//   pronto             one-cycle pulse at the end of each scan
module multi_sonar_scanner
    import sonar_pkg::*;
#(
    parameter int unsigned N_CH       = 3,
    parameter int unsigned CLK_HZ     = 50_000_000,
    parameter int unsigned TRIG_US    = 10,
    parameter int unsigned CYC_PER_CM = 2941,
    parameter int unsigned MAX_CM     = 400,
    parameter int unsigned NOECHO_US  = 30000,
    parameter int unsigned GAP_US     = 1000,
    parameter int unsigned W_DIST     = 9,
    localparam int         CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ligar,
    input  logic              modo,
    input  logic              start,
    input  logic [N_CH-1:0]   ch_mask,
    input  logic [N_CH-1:0]   echo,
    output logic [N_CH-1:0]   trigger,
    output logic [W_DIST-1:0] dist_data,
    output logic [CH_W-1:0]   dist_ch,
    output logic              dist_timeout,
    output logic              dist_valid,
    input  logic              dist_ready,
    output logic              busy,
    output logic              pronto
);

    localparam int unsigned T_TRIG   = us_to_cycles(64'(TRIG_US), 64'(CLK_HZ));
    localparam int unsigned T_NOECHO = us_to_cycles(64'(NOECHO_US), 64'(CLK_HZ));
    localparam int unsigned T_GAP    = us_to_cycles(64'(GAP_US), 64'(CLK_HZ));
    localparam int unsigned T_MAX    = max3(T_TRIG, T_NOECHO, T_GAP);
    localparam int          TMR_W    = $clog2(T_MAX + 1);
    // ch must be able to hold N_CH to signal "past the last channel"
    localparam int          CNT_W    = $clog2(N_CH + 1);
    localparam int          PAD      = 1 << CNT_W;

    scan_state_t       state, state_next;
    logic [TMR_W-1:0]  timer, timer_next;
    logic [CNT_W-1:0]  ch, ch_next;
    logic [N_CH-1:0]   mask_lat;
    logic [N_CH-1:0]   echo_meta, echo_sync;
    logic              echo_prev;
    logic [PAD-1:0]    mask_pad, echo_pad;
    logic              echo_sel, mask_bit, rise;
    logic              mask_load, load_meas, load_noecho;
    logic              m_clear, m_enable, m_done, m_sat;
    logic [W_DIST-1:0] m_cm;

    // Padding to a power of two lets ch index safely even when ch == N_CH
    always_comb begin
        mask_pad           = '0;
        mask_pad[N_CH-1:0] = mask_lat;
        echo_pad           = '0;
        echo_pad[N_CH-1:0] = echo_sync;
    end

    assign echo_sel = echo_pad[ch];
    assign mask_bit = mask_pad[ch];
    // echo_prev tracks the same channel since ch is stable from SELECT on,
    // so an echo already high on entry to WAIT_ECHO is not a rise
    assign rise     = echo_sel && !echo_prev;

    echo_width_meter #(
        .CYC_PER_CM (CYC_PER_CM),
        .MAX_CM     (MAX_CM),
        .W_DIST     (W_DIST)
    ) u_meter (
        .clock     (clock),
        .reset     (reset),
        .clear     (m_clear),
        .enable    (m_enable),
        .echo_in   (echo_sel),
        .cm        (m_cm),
        .done      (m_done),
        .saturated (m_sat)
    );

    always_comb begin
        state_next  = state;
        timer_next  = timer;
        ch_next     = ch;
        mask_load   = 1'b0;
        load_meas   = 1'b0;
        load_noecho = 1'b0;
        m_clear     = 1'b0;
        m_enable    = 1'b0;
        trigger     = '0;
        dist_valid  = 1'b0;
        busy        = 1'b1;
        pronto      = 1'b0;

        case (state)
            ST_IDLE: begin
                busy       = 1'b0;
                timer_next = '0;
                if (ligar && (!modo || start)) begin
                    state_next = ST_SELECT;
                    mask_load  = 1'b1;
                    ch_next    = '0;
                end
            end
            ST_SELECT: begin
                timer_next = '0;
                if (ch > CNT_W'(N_CH - 1)) begin
                    state_next = ST_DONE;
                end else if (!mask_bit) begin
                    ch_next = ch + 1'b1;
                end else begin
                    state_next = ST_TRIG;
                end
            end
            ST_TRIG: begin
                m_clear = 1'b1;
                for (int i = 0; i < N_CH; i++) begin
                    trigger[i] = (ch == CNT_W'(i));
                end
                if (timer == TMR_W'(T_TRIG - 1)) begin
                    state_next = ST_WAIT_ECHO;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ST_WAIT_ECHO: begin
                // The rise cycle itself is counted so the width is exact
                if (rise) begin
                    m_enable   = 1'b1;
                    state_next = ST_MEASURE;
                end else if (timer == TMR_W'(T_NOECHO - 1)) begin
                    load_noecho = 1'b1;
                    state_next  = ST_EMIT;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ST_MEASURE: begin
                m_enable = 1'b1;
                if (m_done) begin
                    load_meas  = 1'b1;
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                dist_valid = 1'b1;
                if (dist_ready) begin
                    state_next = ST_GAP;
                    timer_next = '0;
                end
            end
            ST_GAP: begin
                if (timer == TMR_W'(T_GAP - 1)) begin
                    state_next = ST_SELECT;
                    ch_next    = ch + 1'b1;
                    timer_next = '0;
                end else begin
                    timer_next = timer + 1'b1;
                end
            end
            ST_DONE: begin
                busy       = 1'b0;
                pronto     = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                busy       = 1'b0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= ST_IDLE;
            timer        <= '0;
            ch           <= '0;
            mask_lat     <= '0;
            echo_meta    <= '0;
            echo_sync    <= '0;
            echo_prev    <= 1'b0;
            dist_data    <= '0;
            dist_ch      <= '0;
            dist_timeout <= 1'b0;
        end else begin
            state     <= state_next;
            timer     <= timer_next;
            ch        <= ch_next;
            echo_meta <= echo;
            echo_sync <= echo_meta;
            echo_prev <= echo_sel;
            if (mask_load) mask_lat <= ch_mask;
            if (load_meas) begin
                dist_data    <= m_cm;
                dist_timeout <= m_sat;
                dist_ch      <= ch[CH_W-1:0];
            end
            if (load_noecho) begin
                dist_data    <= W_DIST'(MAX_CM);
                dist_timeout <= 1'b1;
                dist_ch      <= ch[CH_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_multi_sonar_scanner.sv
// Scoreboard testbench for multi_sonar_scanner.
// Runs the scanner at a reduced scale (1 MHz clock, 10 cycles per cm,
// 40 cm range) so every scenario completes in a few thousand cycles.
module tb_multi_sonar_scanner;

    localparam int N_CH     = 3;
    localparam int CYC_CM   = 10;
    localparam int MAX_CM   = 40;
    localparam int GAP_CYC  = 20;
    localparam int ECHO_DLY = 5;

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar, modo, start, dist_ready;
    logic [2:0] ch_mask, echo, trigger;
    logic [8:0] dist_data;
    logic [1:0] dist_ch;
    logic       dist_timeout, dist_valid, busy, pronto;

    typedef struct {
        int ch;
        int data;
        int to;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad = 0;
    int   pronto_cnt = 0;
    int   trig1_cnt = 0;
    int   echo_w[3];

    always #5 clock = ~clock;

    multi_sonar_scanner #(
        .N_CH       (3),
        .CLK_HZ     (1_000_000),
        .TRIG_US    (10),
        .CYC_PER_CM (CYC_CM),
        .MAX_CM     (MAX_CM),
        .NOECHO_US  (300),
        .GAP_US     (GAP_CYC),
        .W_DIST     (9)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .modo         (modo),
        .start        (start),
        .ch_mask      (ch_mask),
        .echo         (echo),
        .trigger      (trigger),
        .dist_data    (dist_data),
        .dist_ch      (dist_ch),
        .dist_timeout (dist_timeout),
        .dist_valid   (dist_valid),
        .dist_ready   (dist_ready),
        .busy         (busy),
        .pronto       (pronto)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d required %0d", name, actual, expected);
        end
    endtask

    // Set echo widths (cycles, 0 = no echo) and queue the hand-computed results
    task automatic apply_stimulus(input int w0, input int w1, input int w2,
                                  input int d0, input int d1, input int d2,
                                  input int t0, input int t1, input int t2,
                                  input logic [2:0] mask);
        int d[3];
        int t[3];
        exp_t e;
        d[0] = d0; d[1] = d1; d[2] = d2;
        t[0] = t0; t[1] = t1; t[2] = t2;
        @(posedge clock); #2;
        echo_w[0] = w0; echo_w[1] = w1; echo_w[2] = w2;
        ch_mask = mask;
        for (int i = 0; i < 3; i++) begin
            if (mask[i]) begin
                e.ch = i; e.data = d[i]; e.to = t[i];
                sb_q.push_back(e);
            end
        end
    endtask

    // which: 0 = pronto, 1 = dist_valid, 2 = busy, 3 = echo[0]
    task automatic wait_for(input int which, input int budget, input string name);
        logic seen;
        logic sig;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            @(negedge clock);
            case (which)
                0:       sig = pronto;
                1:       sig = dist_valid;
                2:       sig = busy;
                default: sig = echo[0];
            endcase
            if (sig) seen = 1'b1;
        end
        check_output(name, 32'(seen), 32'd1);
    endtask

    // Sonar model: echo starts ECHO_DLY cycles after the trigger falls and
    // stays high for exactly echo_w samples
    initial begin
        int         ph[3];
        int         cnt[3];
        logic [2:0] trig_prev;
        echo = '0;
        trig_prev = '0;
        for (int i = 0; i < 3; i++) begin ph[i] = 0; cnt[i] = 0; end
        forever begin
            @(posedge clock); #3;
            if (!reset) begin
                echo = '0;
                trig_prev = '0;
                for (int i = 0; i < 3; i++) ph[i] = 0;
            end else begin
                for (int i = 0; i < 3; i++) begin
                    if (trig_prev[i] && !trigger[i]) begin
                        cnt[i] = ECHO_DLY;
                        ph[i]  = (echo_w[i] > 0) ? 1 : 0;
                    end else if (ph[i] == 1) begin
                        if (cnt[i] == 0) begin
                            echo[i] = 1'b1;
                            cnt[i]  = echo_w[i] - 1;
                            ph[i]   = 2;
                        end else cnt[i]--;
                    end else if (ph[i] == 2) begin
                        if (cnt[i] == 0) begin
                            echo[i] = 1'b0;
                            ph[i]   = 0;
                        end else cnt[i]--;
                    end
                end
                trig_prev = trigger;
            end
        end
    end

    // Monitor: pops the scoreboard on each transfer and checks hold stability
    initial begin
        logic       hold, t1_prev, h_to;
        logic [8:0] h_data;
        logic [1:0] h_ch;
        exp_t       e;
        hold = 1'b0; t1_prev = 1'b0;
        h_data = '0; h_ch = '0; h_to = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                hold = 1'b0;
                t1_prev = 1'b0;
            end else begin
                if (pronto) pronto_cnt++;
                if (trigger[1] && !t1_prev) trig1_cnt++;
                t1_prev = trigger[1];
                if (trigger != 3'b000) check_output("trigger_onehot", 32'($countones(trigger)), 32'd1);
                if (hold) begin
                    check_output("hold_valid", 32'(dist_valid), 32'd1);
                    check_output("hold_data", 32'(dist_data), 32'(h_data));
                    check_output("hold_ch", 32'(dist_ch), 32'(h_ch));
                    check_output("hold_timeout", 32'(dist_timeout), 32'(h_to));
                    check_output("hold_no_trigger", 32'(trigger), 32'd0);
                end
                if (dist_valid && dist_ready) begin
                    if (sb_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("[TB] FAIL unexpected_result: got ch=%0d data=%0d, required no result",
                                 dist_ch, dist_data);
                    end else begin
                        e = sb_q.pop_front();
                        check_output("result_ch", 32'(dist_ch), 32'(e.ch));
                        check_output("result_data", 32'(dist_data), 32'(e.data));
                        check_output("result_timeout", 32'(dist_timeout), 32'(e.to));
                    end
                end
                hold   = dist_valid && !dist_ready;
                h_data = dist_data;
                h_ch   = dist_ch;
                h_to   = dist_timeout;
            end
        end
    end

    initial begin
        int p0;
        int t1;
        int cycles;
        logic seen;
        reset = 1'b0; ligar = 1'b0; modo = 1'b0; start = 1'b0;
        ch_mask = '0; dist_ready = 1'b1;
        for (int i = 0; i < 3; i++) echo_w[i] = 0;

        // Reset state
        repeat (3) @(posedge clock); #1;
        check_output("rst_trigger", 32'(trigger), 32'd0);
        check_output("rst_valid", 32'(dist_valid), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_pronto", 32'(pronto), 32'd0);
        check_output("rst_data", 32'(dist_data), 32'd0);
        check_output("rst_ch", 32'(dist_ch), 32'd0);
        check_output("rst_timeout", 32'(dist_timeout), 32'd0);
        @(posedge clock); #2;
        reset = 1'b1;

        // Continuous scans: rounding, no echo, saturation, ligar falling
        $display("[TB] continuous scans");
        p0 = pronto_cnt;
        apply_stimulus(100, 103, 74, 10, 10, 7, 0, 0, 0, 3'b111);
        modo = 1'b0; ligar = 1'b1;
        wait_for(0, 3000, "scan_a_pronto");
        apply_stimulus(75, 79, 85, 8, 8, 9, 0, 0, 0, 3'b111);
        wait_for(0, 3000, "scan_b_pronto");
        apply_stimulus(20, 0, 36, 2, MAX_CM, 4, 0, 1, 0, 3'b111);
        wait_for(0, 3000, "scan_c_pronto");
        apply_stimulus(450, 55, 64, MAX_CM, 6, 6, 1, 0, 0, 3'b111);
        wait_for(2, 100, "scan_d_busy");
        @(posedge clock); #2;
        ligar = 1'b0;
        wait_for(1, 1000, "sat_valid");
        check_output("sat_echo_still_high", 32'(echo[0]), 32'd1);
        check_output("sat_ch", 32'(dist_ch), 32'd0);
        check_output("sat_timeout", 32'(dist_timeout), 32'd1);
        wait_for(0, 3000, "scan_d_pronto");
        repeat (50) @(negedge clock);
        check_output("ligar_off_idle", 32'(busy), 32'd0);
        check_output("pronto_per_scan", 32'(pronto_cnt - p0), 32'd4);
        check_output("cont_sb_empty", 32'(sb_q.size()), 32'd0);

        // Single shot with mask 101; second start while busy is ignored
        $display("[TB] single shot with mask");
        apply_stimulus(30, 99, 41, 3, 0, 4, 0, 0, 0, 3'b101);
        modo = 1'b1; ligar = 1'b1;
        p0 = pronto_cnt; t1 = trig1_cnt;
        @(posedge clock); #2 start = 1'b1;
        @(posedge clock); #2 start = 1'b0;
        repeat (5) @(posedge clock); #2;
        check_output("single_busy", 32'(busy), 32'd1);
        start = 1'b1;
        @(posedge clock); #2 start = 1'b0;
        wait_for(0, 3000, "single_pronto");
        repeat (100) @(negedge clock);
        check_output("single_one_pronto", 32'(pronto_cnt - p0), 32'd1);
        check_output("single_no_trig1", 32'(trig1_cnt - t1), 32'd0);
        check_output("single_idle", 32'(busy), 32'd0);
        check_output("single_sb_empty", 32'(sb_q.size()), 32'd0);

        // Backpressure: hold ready low, then measure the gap to next trigger
        $display("[TB] backpressure");
        apply_stimulus(50, 60, 0, 5, 6, 0, 0, 0, 0, 3'b011);
        dist_ready = 1'b0;
        @(posedge clock); #2 start = 1'b1;
        @(posedge clock); #2 start = 1'b0;
        wait_for(1, 1000, "bp_valid");
        repeat (100) @(posedge clock);
        #2 dist_ready = 1'b1;
        cycles = 0; seen = 1'b0;
        while (!seen && cycles < 200) begin
            @(posedge clock); #1;
            cycles++;
            if (trigger[1]) seen = 1'b1;
        end
        check_output("bp_next_trigger", 32'(seen), 32'd1);
        check_output("bp_gap_elapsed", 32'((cycles - 1) >= GAP_CYC && (cycles - 1) <= GAP_CYC + 2), 32'd1);
        wait_for(0, 3000, "bp_pronto");
        check_output("bp_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset in the middle of a measurement, then restart from ch 0
        $display("[TB] reset mid measure");
        @(posedge clock); #2;
        echo_w[0] = 300; echo_w[1] = 12; echo_w[2] = 12;
        ch_mask = 3'b111; modo = 1'b0; ligar = 1'b1;
        wait_for(3, 500, "rm_echo_high");
        repeat (50) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check_output("rm_trigger", 32'(trigger), 32'd0);
        check_output("rm_valid", 32'(dist_valid), 32'd0);
        check_output("rm_busy", 32'(busy), 32'd0);
        check_output("rm_pronto", 32'(pronto), 32'd0);
        sb_q.delete();
        repeat (3) @(posedge clock);
        apply_stimulus(12, 18, 27, 1, 2, 3, 0, 0, 0, 3'b111);
        reset = 1'b1;
        wait_for(2, 100, "rm_restart_busy");
        @(posedge clock); #2 ligar = 1'b0;
        wait_for(0, 3000, "rm_pronto");
        repeat (20) @(negedge clock);
        check_output("rm_idle", 32'(busy), 32'd0);
        check_output("end_sb_empty", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
